// File: rtl/rf_scoreboard_pkg.sv
// Shared definitions for the register-file write scoreboard.
// Holds the default geometry and the bit positions of the error causes
// that feed the sticky err flag.
package rf_scoreboard_pkg;

  localparam int AW            = 5;
  localparam int DEPTH_DEFAULT = 4;

  // Bit positions in the per-cycle error-cause vector
  localparam int ERR_ORDER        = 0;
  localparam int ERR_EMPTY_RETIRE = 1;
  localparam int ERR_COMMIT_OVF   = 2;
  localparam int ERR_CAUSES       = 3;

endpackage

// File: rtl/rf_scoreboard_cam.sv
// Associative match of one register index against the scoreboard entries.
// Only entries flagged in the valid mask take part in the compare.
module rf_scoreboard_cam #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic [DEPTH-1:0][AW-1:0] entries,
  input  logic [DEPTH-1:0]         valid,
  input  logic [AW-1:0]            idx,
  output logic                     match
);
  import rf_scoreboard_pkg::*;

  // OR-reduce the per-entry equality compares
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i] == idx)) match = 1'b1;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// In-order RAW-hazard scoreboard for the register-file write port.
// Destination indices are queued from ID issue until WB retire; a commit
// pointer separates entries that survive a flush from squashable ones.
// Optional build macro: RF_SCOREBOARD_BYPASS_EN (a head entry retiring this
// cycle with a matching write no longer stalls ID; needs a write-through RF).
module rf_scoreboard #(
  parameter int DEPTH = rf_scoreboard_pkg::DEPTH_DEFAULT,
  parameter int AW    = rf_scoreboard_pkg::AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_fire,
  input  logic                   issue_wen,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   rs1_ren,
  input  logic [AW-1:0]          rs1,
  input  logic                   rs2_ren,
  input  logic [AW-1:0]          rs2,
  input  logic                   commit_fire,
  input  logic                   retire_wen,
  input  logic [AW-1:0]          retire_rd,
  input  logic                   flush,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] inflight_cnt,
  output logic                   err
);
  import rf_scoreboard_pkg::*;

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointers carry a wrap bit so full and empty are distinguishable
  logic [PW-1:0]            head_q, cmt_q, tail_q;
  logic [PW-1:0]            head_d, cmt_d, tail_d;
  logic [DEPTH-1:0][AW-1:0] rd_q;
  logic                     err_q;
  logic [ERR_CAUSES-1:0]    err_cause;

  logic [PW-1:0]    cnt;
  logic             empty, at_cap;
  logic [AW-1:0]    head_rd;
  logic             retire_req, do_pop, push;
  logic [DEPTH-1:0] valid, stall_mask;
  logic             match1, match2, hazard, full;

  assign cnt        = tail_q - head_q;
  assign empty      = (head_q == tail_q);
  assign at_cap     = (cnt == PW'(DEPTH));
  assign head_rd    = rd_q[head_q[IW-1:0]];
  assign retire_req = retire_wen && (retire_rd != '0);
  assign do_pop     = retire_req && !empty;
  // x0 is never tracked; a same-cycle flush drops the push, and a push into
  // a full queue is only taken when the head leaves this cycle
  assign push       = issue_fire && issue_wen && (issue_rd != '0) && !flush &&
                      !(at_cap && !do_pop);

  // Next pointer state: retire first, then commit, then flush or push
  always_comb begin
    head_d    = head_q;
    cmt_d     = cmt_q;
    tail_d    = tail_q;
    err_cause = '0;
    if (retire_req) begin
      if (empty) begin
        err_cause[ERR_EMPTY_RETIRE] = 1'b1;
      end else begin
        if (retire_rd != head_rd) err_cause[ERR_ORDER] = 1'b1;
        if (cmt_q == head_q) cmt_d = cmt_q + PW'(1);
        head_d = head_q + PW'(1);
      end
    end
    if (commit_fire) begin
      if (cmt_d == tail_q) err_cause[ERR_COMMIT_OVF] = 1'b1;
      else                 cmt_d = cmt_d + PW'(1);
    end
    if (flush)     tail_d = cmt_d;
    else if (push) tail_d = tail_q + PW'(1);
  end

  // Control state: pointers and the sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
      err_q  <= err_q | (|err_cause);
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) rd_q[tail_q[IW-1:0]] <= issue_rd;
  end

  // An entry is live when its distance from head is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [IW-1:0] off;
    assign off      = IW'(i) - head_q[IW-1:0];
    assign valid[i] = ({1'b0, off} < cnt);
  end

`ifdef RF_SCOREBOARD_BYPASS_EN
  // Hide the head entry when it is being written back this very cycle
  always_comb begin
    stall_mask = valid;
    if (do_pop && (retire_rd == head_rd)) stall_mask[head_q[IW-1:0]] = 1'b0;
  end
`else
  assign stall_mask = valid;
`endif

  rf_scoreboard_cam #(.DEPTH(DEPTH), .AW(AW)) u_cam_rs1 (
    .entries (rd_q),
    .valid   (stall_mask),
    .idx     (rs1),
    .match   (match1)
  );

  rf_scoreboard_cam #(.DEPTH(DEPTH), .AW(AW)) u_cam_rs2 (
    .entries (rd_q),
    .valid   (stall_mask),
    .idx     (rs2),
    .match   (match2)
  );

  assign hazard       = (rs1_ren && (rs1 != '0) && match1) ||
                        (rs2_ren && (rs2 != '0) && match2);
  assign full         = at_cap && !retire_req;
  assign stall        = hazard || full;
  assign inflight_cnt = cnt;
  assign err          = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard (DEPTH=4, AW=5).
module tb_rf_scoreboard;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RF_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_fire, issue_wen, rs1_ren, rs2_ren;
  logic          commit_fire, retire_wen, flush;
  logic [AW-1:0] issue_rd, rs1, rs2, retire_rd;
  logic          stall, err;
  logic [CW-1:0] inflight_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_scoreboard #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_fire   (issue_fire),
    .issue_wen    (issue_wen),
    .issue_rd     (issue_rd),
    .rs1_ren      (rs1_ren),
    .rs1          (rs1),
    .rs2_ren      (rs2_ren),
    .rs2          (rs2),
    .commit_fire  (commit_fire),
    .retire_wen   (retire_wen),
    .retire_rd    (retire_rd),
    .flush        (flush),
    .stall        (stall),
    .inflight_cnt (inflight_cnt),
    .err          (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_fire  = 1'b0; issue_wen = 1'b0; issue_rd  = '0;
    rs1_ren     = 1'b0; rs1       = '0;   rs2_ren   = 1'b0; rs2 = '0;
    commit_fire = 1'b0; retire_wen = 1'b0; retire_rd = '0;  flush = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] r);
    issue_fire = 1'b1; issue_wen = 1'b1; issue_rd = r;
  endtask

  task automatic pulse_reset;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", inflight_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_raw;
    push(5'd5);
    rs1_ren = 1'b1; rs1 = 5'd5;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_same_cycle got=%b want=0", stall); end
    tick();
    issue_fire = 1'b0; issue_wen = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall got=%b want=1", stall); end
    checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL raw_cnt got=%0d want=1", inflight_cnt); end
    retire_wen = 1'b1; retire_rd = 5'd5;
    #1;
    checks++; if (stall !== !BYP) begin errors++; $display("FAIL raw_retire_cycle got=%b want=%b", stall, !BYP); end
    tick();
    retire_wen = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_after_retire got=%b want=0", stall); end
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL raw_cnt_after got=%0d want=0", inflight_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL raw_err got=%b want=0", err); end
    idle();
  endtask

  task automatic test_x0;
    push(5'd0);
    tick();
    issue_fire = 1'b1; issue_wen = 1'b0; issue_rd = 5'd6;
    tick();
    idle();
    rs1_ren = 1'b1; rs1 = 5'd0; rs2_ren = 1'b1; rs2 = 5'd6;
    #1;
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL x0_cnt got=%0d want=0", inflight_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall got=%b want=0", stall); end
    idle();
  endtask

  task automatic test_full_wrap;
    int q[$];
    for (int i = 1; i <= 4; i++) begin
      push(AW'(i));
      tick();
      q.push_back(i);
    end
    idle();
    #1;
    checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d want=4", inflight_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got=%b want=1", stall); end
    retire_wen = 1'b1; retire_rd = 5'd1;
    push(5'd5);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_retire_release got=%b want=0", stall); end
    tick();
    void'(q.pop_front());
    q.push_back(5);
    // Three full rounds of simultaneous retire and push through the wrap
    for (int k = 0; k < 12; k++) begin
      retire_wen = 1'b1; retire_rd = AW'(q[0]);
      push(AW'(6 + k));
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wrap_stall_%0d got=%b want=0", k, stall); end
      tick();
      void'(q.pop_front());
      q.push_back(6 + k);
    end
    idle();
    #1;
    checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL wrap_cnt got=%0d want=4", inflight_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_order_err got=%b want=0", err); end
    while (q.size() > 0) begin
      retire_wen = 1'b1; retire_rd = AW'(q.pop_front());
      tick();
    end
    idle();
    #1;
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL drain_cnt got=%0d want=0", inflight_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drain_err got=%b want=0", err); end
  endtask

  task automatic test_flush;
    push(5'd7); tick();
    push(5'd8); tick();
    push(5'd9); tick();
    idle();
    commit_fire = 1'b1; tick();
    commit_fire = 1'b0;
    flush = 1'b1; tick();
    idle();
    #1;
    checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL flush_cnt got=%0d want=1", inflight_cnt); end
    rs1_ren = 1'b1; rs1 = 5'd7; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_keep7 got=%b want=1", stall); end
    rs1 = 5'd8; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_drop8 got=%b want=0", stall); end
    rs1 = 5'd9; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_drop9 got=%b want=0", stall); end
    idle();
    flush = 1'b1; push(5'd10); tick();
    idle();
    rs1_ren = 1'b1; rs1 = 5'd10; #1;
    checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL flush_push_cnt got=%0d want=1", inflight_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_push_10 got=%b want=0", stall); end
    idle();
  endtask

  task automatic test_err;
    // head holds 7 from the flush scenario
    retire_wen = 1'b1; retire_rd = 5'd3; tick();
    idle();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL order_err got=%b want=1", err); end
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL order_pop_cnt got=%0d want=0", inflight_cnt); end
    tick(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b want=1", err); end
    pulse_reset();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b want=0", err); end
    retire_wen = 1'b1; retire_rd = 5'd4; tick();
    idle();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_retire_err got=%b want=1", err); end
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL empty_retire_cnt got=%0d want=0", inflight_cnt); end
  endtask

  task automatic test_mid_reset;
    pulse_reset();
    push(5'd11); tick();
    push(5'd12); tick();
    push(5'd13); tick();
    idle();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL commit_pre_err got=%b want=0", err); end
    for (int i = 0; i < 4; i++) begin
      commit_fire = 1'b1; tick();
    end
    idle();
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL commit_ovf_err got=%b want=1", err); end
    checks++; if (inflight_cnt !== 3'd3) begin errors++; $display("FAIL commit_ovf_cnt got=%0d want=3", inflight_cnt); end
    rst = 1'b1; tick();
    rst = 1'b0;
    rs1_ren = 1'b1; rs1 = 5'd11;
    #1;
    checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL midrst_cnt got=%0d want=0", inflight_cnt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got=%b want=0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b want=0", err); end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_full_wrap();
    test_flush();
    test_err();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
